hht_gather_engine: RTL and testbench

//  Parametrised successor to the HHT control front-end: streams COL_COUNT column indices from the index

---
 rtl/hht_pkg.sv | 27 ++
 rtl/hht_sync_fifo.sv | 61 ++++++
 rtl/hht_gather_engine.sv | 164 ++++++++++++++++
 tb/tb_hht_gather_engine.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hht_pkg.sv
`default_nettype none
// ==== hht_pkg : shared FSM state and FIFO entry layout for the HHT gather engine ====
// Revision 1.0
package hht_pkg;

   localparam int HHT_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // FIFO entry as packed by the engine at the default word width: {data, idx, oob}
   typedef struct packed {
      logic [HHT_DATA_W-1:0] data;
      logic [HHT_DATA_W-1:0] idx;
      logic                  oob;
   } fifo_entry_t;

   function automatic int entry_width(input int data_w);
      return 2 * data_w + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hht_sync_fifo.sv
`default_nettype none
// ==== hht_sync_fifo : synchronous FIFO with registered storage and occupancy output ====
// Revision 1.0
module hht_sync_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic                     valid,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] count;
   logic             empty;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == LVL_W'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so push at full is still taken
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + LVL_W'(1);
            2'b01:   count <= count - LVL_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign valid = !empty;
   assign head  = mem[rd_ptr];
   assign level = count;

endmodule
`default_nettype wire

// File: rtl/hht_gather_engine.sv
`default_nettype none
// ==== hht_gather_engine : streams column indices, gathers vec[idx] and queues (value, index) pairs ====
// Revision 1.0
module hht_gather_engine
   import hht_pkg::*;
#(
   parameter int DATA_W     = HHT_DATA_W,
   parameter int ADDR_W     = 32,
   parameter int CNT_W      = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [ADDR_W-1:0]             col_base,
   input  logic [ADDR_W-1:0]             vec_base,
   input  logic [CNT_W-1:0]              col_count,
   input  logic [CNT_W-1:0]              vec_len,
   output logic [ADDR_W-1:0]             idx_addr,
   input  logic [DATA_W-1:0]             idx_data,
   output logic [ADDR_W-1:0]             vec_addr,
   input  logic [DATA_W-1:0]             vec_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_W-1:0]             out_data,
   output logic [DATA_W-1:0]             out_idx,
   output logic                          out_oob,
   output logic                          busy,
   output logic                          done,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int ENTRY_W = entry_width(DATA_W);

   state_t              state;
   state_t              state_next;

   logic [ADDR_W-1:0]   col_base_q;
   logic [ADDR_W-1:0]   vec_base_q;
   logic [CNT_W-1:0]    col_count_q;
   logic [CNT_W-1:0]    vec_len_q;
   logic [CNT_W-1:0]    issued;
   logic [CNT_W-1:0]    popped;
   logic [CNT_W-1:0]    popped_next;

   logic                s1_valid;
   logic [DATA_W-1:0]   idx_reg;
   logic [ADDR_W-1:0]   idx_addr_hold;
   logic [ADDR_W-1:0]   vec_addr_hold;
   logic [ADDR_W-1:0]   idx_addr_now;
   logic [ADDR_W-1:0]   vec_addr_now;

   logic                accept_start;
   logic                issue;
   logic                pop;
   logic                oob_now;
   logic [ENTRY_W-1:0]  push_entry;
   logic [ENTRY_W-1:0]  head_entry;
   logic [LVL_W-1:0]    fifo_level;
   logic                fifo_valid;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start) state_next = (col_count == '0) ? ST_DONE : ST_RUN;
         ST_RUN:   if (issued == col_count_q) state_next = ST_DRAIN;
         ST_DRAIN: if (popped_next == col_count_q) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Credit check counts the element already in stage 1, so a push can never find the FIFO full.
   always_comb begin
      busy         = (state != ST_IDLE);
      done         = (state == ST_DONE);
      accept_start = (state == ST_IDLE) && start;
      issue        = (state == ST_RUN) && (issued < col_count_q) &&
                     ((fifo_level + LVL_W'(s1_valid)) < LVL_W'(FIFO_DEPTH));
   end

   assign pop         = fifo_valid && out_ready;
   assign popped_next = popped + CNT_W'(pop);

   // ---------------- Job registers and counters ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_base_q  <= '0;
         vec_base_q  <= '0;
         col_count_q <= '0;
         vec_len_q   <= '0;
         issued      <= '0;
         popped      <= '0;
      end else if (accept_start) begin
         col_base_q  <= col_base;
         vec_base_q  <= vec_base;
         col_count_q <= col_count;
         vec_len_q   <= vec_len;
         issued      <= '0;
         popped      <= '0;
      end else begin
         if (issue) issued <= issued + CNT_W'(1);
         popped <= popped_next;
      end
   end

   // ---------------- Gather pipeline ----------------
   assign idx_addr_now = col_base_q + ADDR_W'(issued);
   assign vec_addr_now = vec_base_q + ADDR_W'(idx_reg);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid      <= 1'b0;
         idx_reg       <= '0;
         idx_addr_hold <= '0;
         vec_addr_hold <= '0;
      end else begin
         s1_valid <= issue;
         if (issue) begin
            idx_reg       <= idx_data;
            idx_addr_hold <= idx_addr_now;
         end
         if (s1_valid) vec_addr_hold <= vec_addr_now;
      end
   end

   // Memory addresses present the live lookup only while it is in use, otherwise the last one
   assign idx_addr = issue    ? idx_addr_now : idx_addr_hold;
   assign vec_addr = s1_valid ? vec_addr_now : vec_addr_hold;

   assign oob_now    = (idx_reg >= DATA_W'(vec_len_q));
   assign push_entry = {(oob_now ? {DATA_W{1'b0}} : vec_data), idx_reg, oob_now};

   hht_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (s1_valid),
      .push_data (push_entry),
      .pop       (out_ready),
      .valid     (fifo_valid),
      .head      (head_entry),
      .level     (fifo_level)
   );

   assign out_valid = fifo_valid;
   assign out_data  = head_entry[ENTRY_W-1 -: DATA_W];
   assign out_idx   = head_entry[DATA_W:1];
   assign out_oob   = head_entry[0];
   assign level     = fifo_level;

endmodule
`default_nettype wire

// File: tb/tb_hht_gather_engine.sv
`default_nettype none
// ==== tb_hht_gather_engine : directed self-checking bench for hht_gather_engine ====
// Revision 1.0
module tb_hht_gather_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] col_base = '0;
   logic [31:0] vec_base = '0;
   logic [15:0] col_count = '0;
   logic [15:0] vec_len = '0;
   logic [31:0] idx_addr;
   logic [31:0] idx_data;
   logic [31:0] vec_addr;
   logic [31:0] vec_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [31:0] out_idx;
   logic        out_oob;
   logic        busy;
   logic        done;
   logic [3:0]  level;

   int checks = 0;
   int failures = 0;

   logic [31:0] idx_tbl [0:19] = '{2, 6, 2, 12, 0, 9, 8, 5, 1, 15, 3, 7, 11, 4, 13, 10, 14, 6, 0, 9};
   logic [31:0] vec_tbl [0:15] = '{74, 10, 70, 18, 85, 61, 83, 92, 98, 0, 73, 11, 92, 36, 82, 71};

   logic [31:0] got_data [$];
   logic [31:0] got_idx  [$];
   logic        got_oob  [$];
   logic [31:0] exp_data [$];
   logic [31:0] exp_idx  [$];
   logic        exp_oob  [$];

   int first_valid;
   int done_cyc;
   int done_cnt;
   int busy_cyc;
   int max_level;

   always #5 clk = ~clk;

   // Combinational-read memories
   always_comb begin
      idx_data = 32'hFFFF_FFFF;
      if (idx_addr >= 32'd180 && idx_addr < 32'd200) idx_data = idx_tbl[5'(idx_addr - 32'd180)];
   end

   always_comb begin
      vec_data = 32'hBAD0_0000;
      if (vec_addr >= 32'd2 && vec_addr < 32'd18) vec_data = vec_tbl[4'(vec_addr - 32'd2)];
   end

   hht_gather_engine dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .col_base  (col_base),
      .vec_base  (vec_base),
      .col_count (col_count),
      .vec_len   (vec_len),
      .idx_addr  (idx_addr),
      .idx_data  (idx_data),
      .vec_addr  (vec_addr),
      .vec_data  (vec_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_oob   (out_oob),
      .busy      (busy),
      .done      (done),
      .level     (level)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_idx_addr"},  idx_addr,  0);
      chk({tag, "_vec_addr"},  vec_addr,  0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_busy"},      busy,      0);
      chk({tag, "_done"},      done,      0);
      chk({tag, "_level"},     level,     0);
   endtask

   task automatic check_seq(input string tag);
      chk({tag, "_count"}, got_data.size(), exp_data.size());
      foreach (exp_data[i]) begin
         chk($sformatf("%s_data%0d", tag, i), (i < got_data.size()) ? got_data[i] : 'x, exp_data[i]);
         chk($sformatf("%s_idx%0d",  tag, i), (i < got_idx.size())  ? got_idx[i]  : 'x, exp_idx[i]);
         chk($sformatf("%s_oob%0d",  tag, i), (i < got_oob.size())  ? got_oob[i]  : 1'bx, exp_oob[i]);
      end
   endtask

   // Optionally pulses start, then samples every falling edge (cycle 1 = first cycle after start)
   // until a done pulse has been seen and the engine has returned to idle, or the budget runs out.
   task automatic collect(input bit do_start, input int budget, input int repulse_cyc);
      got_data.delete();
      got_idx.delete();
      got_oob.delete();
      first_valid = -1;
      done_cyc    = -1;
      done_cnt    = 0;
      busy_cyc    = 0;
      max_level   = 0;
      if (do_start) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      for (int c = 1; c <= budget; c++) begin
         if (out_valid && first_valid < 0) first_valid = c;
         if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_idx.push_back(out_idx);
            got_oob.push_back(out_oob);
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (busy) busy_cyc++;
         if (int'(level) > max_level) max_level = int'(level);
         start = (c == repulse_cyc);
         if (c == repulse_cyc) begin
            col_base  = 32'd0;
            col_count = 16'd3;
         end
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
         @(negedge clk);
      end
      start = 1'b0;
      chk("done_within_budget", (done_cyc >= 0), 1);
   endtask

   task automatic setup_basic(input logic [15:0] vlen);
      col_base  = 32'd180;
      vec_base  = 32'd2;
      col_count = 16'd5;
      vec_len   = vlen;
      out_ready = 1'b1;
      exp_data  = '{70, 83, 70, 92, 74};
      exp_idx   = '{2, 6, 2, 12, 0};
      exp_oob   = '{0, 0, 0, 0, 0};
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      check_idle_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 1: basic gather, all in bounds
      setup_basic(16'd16);
      collect(1'b1, 200, -1);
      check_seq("t1");
      chk("t1_first_valid_cycle", first_valid, 3);
      chk("t1_done_cycle", done_cyc, 8);
      chk("t1_done_pulses", done_cnt, 1);
      chk("t1_idle_after", busy, 0);

      // 2: vec_len=10 makes index 12 out of bounds
      setup_basic(16'd10);
      exp_data = '{70, 83, 70, 0, 74};
      exp_oob  = '{0, 0, 0, 1, 0};
      collect(1'b1, 200, -1);
      check_seq("t2");

      // 3: consumer stalled, FIFO fills to depth and issue stops
      col_base  = 32'd180;
      vec_base  = 32'd2;
      col_count = 16'd20;
      vec_len   = 16'd16;
      out_ready = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      max_level = 0;
      for (int c = 0; c < 20; c++) begin
         if (int'(level) > max_level) max_level = int'(level);
         @(negedge clk);
      end
      chk("t3_level_full", level, 8);
      chk("t3_level_max", max_level, 8);
      chk("t3_idx_addr_held", idx_addr, 187);
      chk("t3_head_valid", out_valid, 1);
      chk("t3_head_data", out_data, 70);
      chk("t3_head_idx", out_idx, 2);
      chk("t3_busy", busy, 1);
      exp_data = '{70, 83, 70, 92, 74, 0, 98, 61, 10, 71, 18, 92, 11, 85, 36, 73, 82, 83, 74, 0};
      exp_idx  = '{2, 6, 2, 12, 0, 9, 8, 5, 1, 15, 3, 7, 11, 4, 13, 10, 14, 6, 0, 9};
      exp_oob  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      out_ready = 1'b1;
      collect(1'b0, 300, -1);
      check_seq("t3");
      chk("t3_done_pulses", done_cnt, 1);

      // 4: zero-length job goes straight to done
      col_count = 16'd0;
      collect(1'b1, 20, -1);
      chk("t4_pops", got_data.size(), 0);
      chk("t4_never_valid", first_valid, -1);
      chk("t4_busy_cycles", busy_cyc, 1);
      chk("t4_done_cycle", done_cyc, 1);
      chk("t4_done_pulses", done_cnt, 1);

      // 5: reset mid-run after three pops, then a clean rerun
      col_base  = 32'd180;
      vec_base  = 32'd2;
      col_count = 16'd10;
      vec_len   = 16'd16;
      out_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      done_cnt = 0;
      for (int c = 0, n = 0; c < 50 && n < 3; c++) begin
         if (out_valid && out_ready) n++;
         if (done) done_cnt++;
         if (n < 3) @(negedge clk);
      end
      chk("t5_busy_before_reset", busy, 1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_idle_outputs("t5_abort");
      chk("t5_no_done_before_abort", done_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      setup_basic(16'd16);
      collect(1'b1, 200, -1);
      check_seq("t5_rerun");
      chk("t5_rerun_done_pulses", done_cnt, 1);

      // 6: start re-pulsed during RUN with different job values is ignored
      setup_basic(16'd16);
      collect(1'b1, 200, 2);
      check_seq("t6");
      chk("t6_done_pulses", done_cnt, 1);
      chk("t6_done_cycle", done_cyc, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute safety net against a hung run
   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end

endmodule
`default_nettype wire
